// File: rtl/mem_dbus_sequencer.sv
// Shares one data-bus port between the two memory issue slots: slot 1 first, then slot 2,
// with kill/flush handling and load-result holding until the write stage takes the pair.
module mem_dbus_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        req1_valid,
  input  logic [31:0] req1_addr,
  input  logic [2:0]  req1_size,
  input  logic [3:0]  req1_strobe,
  input  logic [31:0] req1_wdata,
  input  logic        req2_valid,
  input  logic [31:0] req2_addr,
  input  logic [2:0]  req2_size,
  input  logic [3:0]  req2_strobe,
  input  logic [31:0] req2_wdata,
  input  logic        kill2,
  input  logic        flush,
  input  logic        advance,
  output logic        dbus_valid,
  output logic [31:0] dbus_addr,
  output logic [2:0]  dbus_size,
  output logic [3:0]  dbus_strobe,
  output logic [31:0] dbus_wdata,
  input  logic        dbus_addr_ok,
  input  logic        dbus_data_ok,
  input  logic [31:0] dbus_rdata,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2,
  output logic        done,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, ISSUE1, WAIT1, ISSUE2, WAIT2, DONE, DRAIN} state_t;

  state_t      state_reg, state_next;
  logic [31:0] rdata1_reg, rdata1_next;
  logic [31:0] rdata2_reg, rdata2_next;
  logic        go2, load1, load2;

  assign go2   = req2_valid & ~kill2;
  assign load1 = (req1_strobe == 4'b0000);
  assign load2 = (req2_strobe == 4'b0000);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= IDLE;
      rdata1_reg <= 32'h0;
      rdata2_reg <= 32'h0;
    end else begin
      state_reg  <= state_next;
      rdata1_reg <= rdata1_next;
      rdata2_reg <= rdata2_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    rdata1_next = rdata1_reg;
    rdata2_next = rdata2_reg;
    dbus_valid  = 1'b0;
    dbus_addr   = 32'h0;
    dbus_size   = 3'h0;
    dbus_strobe = 4'h0;
    dbus_wdata  = 32'h0;
    done        = 1'b0;

    case (state_reg)
      IDLE: begin
        done = ~req1_valid & ~go2;
        if (!flush) begin
          if (req1_valid)
            state_next = ISSUE1;
          else if (go2)
            state_next = ISSUE2;
        end
      end

      ISSUE1: begin
        dbus_valid  = 1'b1;
        dbus_addr   = req1_addr;
        dbus_size   = req1_size;
        dbus_strobe = req1_strobe;
        dbus_wdata  = req1_wdata;
        if (flush) begin
          state_next = (dbus_addr_ok && !dbus_data_ok) ? DRAIN : IDLE;
        end else if (dbus_addr_ok && dbus_data_ok) begin
          if (load1)
            rdata1_next = dbus_rdata;
          state_next = go2 ? ISSUE2 : DONE;
        end else if (dbus_addr_ok) begin
          state_next = WAIT1;
        end
      end

      WAIT1: begin
        if (dbus_data_ok) begin
          if (!flush && load1)
            rdata1_next = dbus_rdata;
          state_next = flush ? IDLE : (go2 ? ISSUE2 : DONE);
        end else if (flush) begin
          state_next = DRAIN;
        end
      end

      ISSUE2: begin
        // A late kill before acceptance drops the request without touching the bus.
        if (kill2) begin
          state_next = flush ? IDLE : DONE;
        end else begin
          dbus_valid  = 1'b1;
          dbus_addr   = req2_addr;
          dbus_size   = req2_size;
          dbus_strobe = req2_strobe;
          dbus_wdata  = req2_wdata;
          if (flush) begin
            state_next = (dbus_addr_ok && !dbus_data_ok) ? DRAIN : IDLE;
          end else if (dbus_addr_ok && dbus_data_ok) begin
            if (load2)
              rdata2_next = dbus_rdata;
            state_next = DONE;
          end else if (dbus_addr_ok) begin
            state_next = WAIT2;
          end
        end
      end

      WAIT2: begin
        if (dbus_data_ok) begin
          if (!flush && load2)
            rdata2_next = dbus_rdata;
          state_next = flush ? IDLE : DONE;
        end else if (flush) begin
          state_next = DRAIN;
        end
      end

      DONE: begin
        done = 1'b1;
        if (flush || advance)
          state_next = IDLE;
      end

      DRAIN: begin
        if (dbus_data_ok)
          state_next = IDLE;
      end

      default: state_next = IDLE;
    endcase
  end

  assign busy   = ~done;
  assign rdata1 = rdata1_reg;
  assign rdata2 = rdata2_reg;

endmodule

// File: tb/tb_mem_dbus_sequencer.sv
// Directed bench for mem_dbus_sequencer: a bus responder task plus a scoreboard of
// expected load results compared whenever the sequencer reports a completed pair.
module tb_mem_dbus_sequencer;

  logic        clk;
  logic        reset;
  logic        req1_valid, req2_valid;
  logic [31:0] req1_addr, req2_addr, req1_wdata, req2_wdata;
  logic [2:0]  req1_size, req2_size;
  logic [3:0]  req1_strobe, req2_strobe;
  logic        kill2, flush, advance;
  logic        dbus_valid;
  logic [31:0] dbus_addr, dbus_wdata;
  logic [2:0]  dbus_size;
  logic [3:0]  dbus_strobe;
  logic        dbus_addr_ok, dbus_data_ok;
  logic [31:0] dbus_rdata;
  logic [31:0] rdata1, rdata2;
  logic        done, busy;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] m1, m2;
  int waited;

  mem_dbus_sequencer dut (
    .clk(clk), .reset(reset),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_size(req1_size),
    .req1_strobe(req1_strobe), .req1_wdata(req1_wdata),
    .req2_valid(req2_valid), .req2_addr(req2_addr), .req2_size(req2_size),
    .req2_strobe(req2_strobe), .req2_wdata(req2_wdata),
    .kill2(kill2), .flush(flush), .advance(advance),
    .dbus_valid(dbus_valid), .dbus_addr(dbus_addr), .dbus_size(dbus_size),
    .dbus_strobe(dbus_strobe), .dbus_wdata(dbus_wdata),
    .dbus_addr_ok(dbus_addr_ok), .dbus_data_ok(dbus_data_ok), .dbus_rdata(dbus_rdata),
    .rdata1(rdata1), .rdata2(rdata2), .done(done), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_req1(input logic v, input logic [31:0] a, input logic [3:0] st, input logic [31:0] wd);
    req1_valid = v; req1_addr = a; req1_size = 3'd2; req1_strobe = st; req1_wdata = wd;
  endtask

  task automatic set_req2(input logic v, input logic [31:0] a, input logic [3:0] st, input logic [31:0] wd);
    req2_valid = v; req2_addr = a; req2_size = 3'd2; req2_strobe = st; req2_wdata = wd;
  endtask

  // Called just after a falling edge; returns just after the falling edge that follows data_ok.
  task automatic serve(input logic [31:0] a, input logic [3:0] st, input logic [31:0] wd,
                       input logic [31:0] rd, input int aok_dly, input int dok_dly,
                       output int w);
    w = 0;
    #1;
    while (dbus_valid !== 1'b1 && w < 20) begin
      @(negedge clk); #1; w++;
    end
    chk("issue_seen", dbus_valid, 1);
    for (int i = 0; i <= aok_dly; i++) begin
      if (i > 0) begin @(negedge clk); #1; end
      chk("dbus_addr", dbus_addr, a);
      chk("dbus_size", dbus_size, 3'd2);
      chk("dbus_strobe", dbus_strobe, st);
      chk("dbus_wdata", dbus_wdata, wd);
      chk("issue_busy", busy, 1);
    end
    dbus_addr_ok = 1'b1;
    dbus_data_ok = (dok_dly == 0);
    dbus_rdata   = rd;
    @(negedge clk);
    dbus_addr_ok = 1'b0;
    dbus_data_ok = 1'b0;
    dbus_rdata   = 32'h0;
    for (int k = 1; k <= dok_dly; k++) begin
      #1;
      chk("wait_valid", dbus_valid, 0);
      chk("wait_busy", busy, 1);
      chk("wait_done", done, 0);
      if (k == dok_dly) begin
        dbus_data_ok = 1'b1;
        dbus_rdata   = rd;
      end
      @(negedge clk);
      dbus_data_ok = 1'b0;
      dbus_rdata   = 32'h0;
    end
    $display("txn addr=%h strobe=%h rdata=%h issue_wait=%0d aok_dly=%0d dok_dly=%0d",
             a, st, rd, w, aok_dly, dok_dly);
  endtask

  task automatic wait_done(output int w);
    logic [31:0] e1, e2;
    w = 0;
    #1;
    while (done !== 1'b1 && w < 50) begin
      @(negedge clk); #1; w++;
    end
    chk("done_seen", done, 1);
    chk("done_busy", busy, 0);
    if (exp_q.size() >= 2) begin
      e1 = exp_q.pop_front();
      e2 = exp_q.pop_front();
      chk("sb_rdata1", rdata1, e1);
      chk("sb_rdata2", rdata2, e2);
      $display("pair done wait=%0d rdata1=%h rdata2=%h", w, rdata1, rdata2);
    end else begin
      chk("sb_underflow", exp_q.size(), 2);
    end
    advance = 1'b1;
    set_req1(1'b0, 32'h0, 4'h0, 32'h0);
    set_req2(1'b0, 32'h0, 4'h0, 32'h0);
    kill2 = 1'b0;
    @(negedge clk);
    advance = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    set_req1(1'b0, 32'h0, 4'h0, 32'h0);
    set_req2(1'b0, 32'h0, 4'h0, 32'h0);
    kill2 = 0; flush = 0; advance = 0;
    dbus_addr_ok = 0; dbus_data_ok = 0; dbus_rdata = 32'h0;
    m1 = 32'h0; m2 = 32'h0;

    #1;
    chk("rst_valid", dbus_valid, 0);
    chk("rst_done", done, 1);
    chk("rst_busy", busy, 0);
    chk("rst_rdata1", rdata1, 0);
    chk("rst_rdata2", rdata2, 0);
    @(negedge clk);
    reset = 1'b0;

    // Two single-cycle loads: consecutive issue, done in cycle 3.
    set_req1(1'b1, 32'h1000, 4'h0, 32'h0);
    set_req2(1'b1, 32'h2000, 4'h0, 32'h0);
    #1;
    chk("idle_req_busy", busy, 1);
    chk("idle_req_valid", dbus_valid, 0);
    @(negedge clk);
    m1 = 32'hAAAA5555; m2 = 32'h12345678;
    exp_q.push_back(m1); exp_q.push_back(m2);
    serve(32'h1000, 4'h0, 32'h0, 32'hAAAA5555, 0, 0, waited);
    chk("t1_issue1_cycle", waited, 0);
    serve(32'h2000, 4'h0, 32'h0, 32'h12345678, 0, 0, waited);
    chk("t1_issue2_back2back", waited, 0);
    wait_done(waited);
    chk("t1_done_cycle3", waited, 0);

    // Slot 1 store with delayed handshake, slot 2 load.
    set_req1(1'b1, 32'h3000, 4'hF, 32'hCAFEF00D);
    set_req2(1'b1, 32'h3004, 4'h0, 32'h0);
    @(negedge clk);
    m2 = 32'h0BADF00D;
    exp_q.push_back(m1); exp_q.push_back(m2);
    serve(32'h3000, 4'hF, 32'hCAFEF00D, 32'hFFFFFFFF, 2, 3, waited);
    serve(32'h3004, 4'h0, 32'h0, 32'h0BADF00D, 0, 0, waited);
    chk("t2_issue2_after_dok", waited, 0);
    wait_done(waited);
    chk("t2_done_cycle", waited, 0);

    // kill2: only slot 1 reaches the bus.
    set_req1(1'b1, 32'h4000, 4'h0, 32'h0);
    set_req2(1'b1, 32'h5000, 4'h0, 32'h0);
    kill2 = 1'b1;
    @(negedge clk);
    m1 = 32'h11112222;
    exp_q.push_back(m1); exp_q.push_back(m2);
    serve(32'h4000, 4'h0, 32'h0, 32'h11112222, 0, 1, waited);
    #1;
    chk("t3_no_slot2_issue", dbus_valid, 0);
    wait_done(waited);
    chk("t3_done_after_slot1", waited, 0);

    // Flush in WAIT1, data arrives two cycles later while draining.
    set_req1(1'b1, 32'h6000, 4'h0, 32'h0);
    @(negedge clk);
    #1;
    chk("t4_issue1", dbus_valid, 1);
    dbus_addr_ok = 1'b1;
    @(negedge clk);
    dbus_addr_ok = 1'b0;
    #1;
    chk("t4_wait1_valid", dbus_valid, 0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    for (int k = 0; k < 2; k++) begin
      #1;
      chk("t4_drain_valid", dbus_valid, 0);
      chk("t4_drain_busy", busy, 1);
      chk("t4_drain_done", done, 0);
      if (k == 1) begin
        dbus_data_ok = 1'b1;
        dbus_rdata   = 32'hDEADBEEF;
        req1_valid   = 1'b0;
      end
      @(negedge clk);
    end
    dbus_data_ok = 1'b0;
    dbus_rdata   = 32'h0;
    #1;
    chk("t4_idle_done", done, 1);
    chk("t4_idle_busy", busy, 0);
    chk("t4_rdata1_kept", rdata1, m1);
    $display("txn flushed addr=00006000 rdata=deadbeef discarded");
    set_req1(1'b1, 32'h7000, 4'h0, 32'h0);
    @(negedge clk);
    m1 = 32'h77770000;
    exp_q.push_back(m1); exp_q.push_back(m2);
    serve(32'h7000, 4'h0, 32'h0, 32'h77770000, 0, 0, waited);
    chk("t4_next_issue", waited, 0);
    wait_done(waited);

    // Flush in ISSUE2 without addr_ok: straight back to IDLE.
    set_req1(1'b1, 32'h8000, 4'h0, 32'h0);
    set_req2(1'b1, 32'h9000, 4'h0, 32'h0);
    @(negedge clk);
    serve(32'h8000, 4'h0, 32'h0, 32'h80808080, 0, 0, waited);
    m1 = 32'h80808080;
    #1;
    chk("t5_issue2_valid", dbus_valid, 1);
    chk("t5_issue2_addr", dbus_addr, 32'h9000);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    set_req1(1'b0, 32'h0, 4'h0, 32'h0);
    set_req2(1'b0, 32'h0, 4'h0, 32'h0);
    #1;
    chk("t5_valid_dropped", dbus_valid, 0);
    chk("t5_idle_done", done, 1);
    chk("t5_idle_busy", busy, 0);
    chk("t5_rdata1", rdata1, m1);
    chk("t5_rdata2", rdata2, m2);
    $display("txn flushed addr=00009000 before addr_ok");

    // Asynchronous reset in the middle of WAIT2.
    @(negedge clk);
    set_req1(1'b1, 32'hA000, 4'h0, 32'h0);
    set_req2(1'b1, 32'hB000, 4'h0, 32'h0);
    @(negedge clk);
    serve(32'hA000, 4'h0, 32'h0, 32'hA5A5A5A5, 0, 0, waited);
    #1;
    chk("t6_issue2_addr", dbus_addr, 32'hB000);
    dbus_addr_ok = 1'b1;
    @(negedge clk);
    dbus_addr_ok = 1'b0;
    #1;
    chk("t6_wait2_valid", dbus_valid, 0);
    chk("t6_wait2_busy", busy, 1);
    chk("t6_pre_reset_rdata1", rdata1, 32'hA5A5A5A5);
    #2;
    reset = 1'b1;
    set_req1(1'b0, 32'h0, 4'h0, 32'h0);
    set_req2(1'b0, 32'h0, 4'h0, 32'h0);
    #1;
    chk("t6_rst_valid", dbus_valid, 0);
    chk("t6_rst_done", done, 1);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_rdata1", rdata1, 0);
    chk("t6_rst_rdata2", rdata2, 0);
    $display("txn reset during WAIT2 addr=0000b000");
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("t6_post_reset_done", done, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_dbus_sequencer.md
# mem_dbus_sequencer

Sequencer that shares the single data-bus port of the dual-issue memory stage between the two issue slots. It serialises slot 1 then slot 2 onto the bus using the valid/addr_ok/data_ok handshake, and drops slot 2 when slot 1 raises an exception. It drains accepted transactions on a pipeline flush and holds both load results until the write stage accepts the pair. It sits between the two memory-slot datapaths and the data cache / bus bridge.

## Interface
Parameters:
- none (widths fixed: 32-bit address/data, 3-bit size, 4-bit strobe)

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- req1_valid  in  1  slot 1 holds a memory access
- req1_addr / req1_size / req1_strobe / req1_wdata  in  32/3/4/32  slot 1 request fields; strobe 0 = load
- req2_valid, req2_addr, req2_size, req2_strobe, req2_wdata  in  1/32/3/4/32  slot 2 equivalents
- kill2  in  1  slot 1 raised an exception, or an earlier exception is pending; slot 2 must not access memory
- flush  in  1  pipeline flush; abandon the pair
- advance  in  1  write stage accepts the completed pair
- dbus_valid  out  1  bus request valid
- dbus_addr / dbus_size / dbus_strobe / dbus_wdata  out  32/3/4/32  fields of the slot currently issuing; 0 when dbus_valid=0
- dbus_addr_ok  in  1  request accepted
- dbus_data_ok  in  1  response valid
- dbus_rdata  in  32  response data
- rdata1, rdata2  out  32  captured load data per slot
- done  out  1  pair complete; results valid
- busy  out  1  stall upstream stages

## Operation
- States: IDLE, ISSUE1, WAIT1, ISSUE2, WAIT2, DONE, DRAIN.
- Upstream holds the req fields and kill2 stable while busy=1. The sequencer reads them combinationally and does not latch them.
- "go2" = req2_valid & !kill2.
- IDLE:
  - req1_valid → ISSUE1.
  - Otherwise go2 → ISSUE2.
  - Otherwise stay in IDLE, with done=1 and busy=0 (pass-through of non-memory pairs).
- ISSUEn:
  - dbus_valid=1; fields driven from slot n.
  - addr_ok & data_ok in the same cycle: capture dbus_rdata into rdatan, then go to the next step.
  - addr_ok only → WAITn.
  - Neither → stay; request held unchanged.
- WAITn:
  - dbus_valid=0.
  - data_ok: capture rdatan, then go to the next step.
- Next step after slot 1: go2 → ISSUE2, else DONE. Next step after slot 2: DONE.
- kill2 seen in ISSUE2 before addr_ok → DONE; the request is dropped, rdata2 is unchanged. After addr_ok, kill2 is ignored for the bus and the transaction completes.
- DONE: done=1, busy=0. advance → IDLE.
- Flush has priority over every other transition:
  - In ISSUEn without addr_ok, or in IDLE/DONE → IDLE.
  - In ISSUEn with addr_ok but no data_ok, or in WAITn without data_ok → DRAIN.
  - With data_ok in the same cycle → IDLE.
  - The result of a flushed access is never captured.
- DRAIN: dbus_valid=0, busy=1, done=0. data_ok → IDLE. Request inputs are ignored.
- busy = !done, except busy=0 in IDLE with no request.
- Loads write rdata only; stores leave rdata unchanged. rdata1 and rdata2 hold their values until the next capture.
- Exactly one outstanding bus transaction at any time.

## Timing
- Reset (async): state IDLE, rdata1=rdata2=0, dbus_valid=0, done=1, busy=0.
- Outputs decode from state and inputs combinationally. The FSM and rdata registers update on the clk edge.
- Minimum latency for a single access with addr_ok & data_ok on first issue: 2 cycles.
  - Cycle 0: IDLE sees request.
  - Cycle 1: ISSUE1 handshake.
  - Cycle 2: DONE.
- Pair of accesses, both single-cycle: 3 cycles to DONE.
- Each cycle of addr_ok delay adds one ISSUE cycle. Each cycle between addr_ok and data_ok adds one WAIT cycle.
- data_ok arriving in DRAIN is consumed in that cycle; IDLE follows in the next cycle.
- advance together with a new request in DONE: IDLE for one cycle, then issue. No back-to-back bypass.

## Test plan
- Two loads with bus addr_ok&data_ok in the same cycle; req1_addr=0x1000 (rdata 0xAAAA5555), req2_addr=0x2000 (rdata 0x12345678):
  - Required: dbus_addr 0x1000 then 0x2000 on consecutive cycles; done at cycle 3; rdata1=0xAAAA5555, rdata2=0x12345678.
- Slot 1 store (strobe 0xF), slot 2 load, bus addr_ok delayed 2 cycles and data_ok 3 cycles after that:
  - Required: dbus fields held stable through the delay; slot 2 not issued until slot 1 data_ok; busy=1 throughout; done=1 only after slot 2 data_ok.
- kill2=1 with both requests valid:
  - Required: only the slot 1 transaction appears on the bus; DONE follows slot 1 data_ok; rdata2 keeps its old value.
- flush in WAIT1, data_ok 2 cycles later with data 0xDEADBEEF:
  - Required: state enters DRAIN; dbus_valid=0; rdata1 unchanged; IDLE follows the data_ok cycle; the next pair issues normally.
- flush in ISSUE2 with addr_ok=0:
  - Required: dbus_valid drops next cycle; no DRAIN; IDLE.
- Reset asserted mid-WAIT2:
  - Required: all outputs return immediately to reset values without waiting for a clock edge.
